// File: rtl/instr_loader_pkg.sv
// Shared definitions for the program loader: word width and FSM states.
// Exposes DEF_WORD_WIDTH, state_t and the is_busy() state helper.
package instr_loader_pkg;

  localparam int DEF_WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_LOAD   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_HEADER) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Packs a big-endian byte stream into W-bit words.
// Ports: clk, reset, i_clr (drop partial word), i_en (byte accepted),
//   i_byte, o_word_valid (word completes this cycle), o_word.
module instr_loader_byte_packer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [7:0]   i_byte,
  output logic         o_word_valid,
  output logic [W-1:0] o_word
);

  localparam int BPW = W / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(BPW - 1));

  // Word is formed combinationally so the loader can
  // register the write on the same edge the last byte lands.
  assign o_word       = (r_shift << 8) | W'(i_byte);
  assign o_word_valid = i_en && w_last;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_en) begin
      r_shift <= o_word;
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Program loader: streams a header word N plus N words into instr memory,
// holding the CPU in reset until done.
// Ports: clk, reset, start, in_data/in_valid/in_ready (byte stream),
//   wr_en/wr_addr/wr_data (memory write), cpu_hold, busy, done, checksum.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] checksum
);

  state_t r_state;
  state_t w_next;

  logic                  r_in_ready;
  logic                  r_wr_en;
  logic [WORD_WIDTH-1:0] r_wr_addr;
  logic [WORD_WIDTH-1:0] r_wr_data;
  logic                  r_cpu_hold;
  logic                  r_busy;
  logic                  r_done;
  logic [WORD_WIDTH-1:0] r_chk;
  logic [WORD_WIDTH-1:0] r_n;
  logic [WORD_WIDTH-1:0] r_idx;

  logic                  w_accept;
  logic                  w_restart;
  logic                  w_word_valid;
  logic [WORD_WIDTH-1:0] w_word;
  logic                  w_last_word;
  logic                  w_hdr_word;
  logic                  w_load_word;

  assign w_accept    = in_valid && r_in_ready;
  assign w_restart   = start &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_word = (r_idx == r_n - WORD_WIDTH'(1));
  assign w_hdr_word  = w_word_valid && (r_state == ST_HEADER);
  assign w_load_word = w_word_valid && (r_state == ST_LOAD);

  instr_loader_byte_packer #(
    .W(WORD_WIDTH)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_restart),
    .i_en         (w_accept),
    .i_byte       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        if (start) w_next = ST_HEADER;
      end
      (r_state == ST_HEADER): begin
        if (w_word_valid)
          w_next = (w_word == '0) ? ST_DONE : ST_LOAD;
      end
      (r_state == ST_LOAD): begin
        if (w_word_valid && w_last_word) w_next = ST_DONE;
      end
      (r_state == ST_DONE): begin
        if (start) w_next = ST_HEADER;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_chk      <= '0;
      r_n        <= '0;
      r_idx      <= '0;
    end else begin
      r_in_ready <= is_busy(w_next);
      r_busy     <= is_busy(w_next);
      r_done     <= (w_next == ST_DONE);
      r_cpu_hold <= (w_next != ST_DONE);
      r_wr_en    <= 1'b0;
      if (w_restart) begin
        r_idx <= '0;
        r_chk <= '0;
      end
      if (w_hdr_word) begin
        r_n   <= w_word;
        r_idx <= '0;
      end
      if (w_load_word) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_idx;
        r_wr_data <= w_word;
        r_chk     <= r_chk + w_word;
        r_idx     <= r_idx + WORD_WIDTH'(1);
      end
    end
  end

  assign in_ready = r_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_cpu_hold;
  assign busy     = r_busy;
  assign done     = r_done;
  assign checksum = r_chk;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: random and directed byte streams,
// expected writes queued from a stream-level model, checked by a monitor.
module tb_instr_loader;

  localparam int WW  = 16;
  localparam int BPW = WW / 8;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [WW-1:0] addr;
    logic [WW-1:0] data;
    logic [WW-1:0] chk;
    bit            last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [WW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic [WW-1:0] checksum;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [WW-1:0] last_sum;
  int            checks = 0;
  int            errors = 0;

  instr_loader #(.WORD_WIDTH(WW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: interpret the stream as header N then N words,
  // queue one write per complete program word with running sum.
  function automatic void model(input byte_q_t b);
    int            n;
    int            pos;
    logic [WW-1:0] w;
    logic [WW-1:0] sum;
    sum      = '0;
    last_sum = '0;
    if (b.size() < BPW) return;
    n = 0;
    for (int j = 0; j < BPW; j++) n = n * 256 + int'(b[j]);
    for (int k = 0; k < n; k++) begin
      pos = BPW * (k + 1);
      if (pos + BPW > b.size()) break;
      w = '0;
      for (int j = 0; j < BPW; j++) w = (w << 8) | WW'(b[pos + j]);
      sum = sum + w;
      sb.push_back('{addr: WW'(k), data: w, chk: sum, last: (k == n - 1)});
    end
    last_sum = sum;
  endfunction

  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (sb.size() == 0) begin
        check("unexpected_wr_en", 32'(wr_en), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(wr_data), 32'(mon_e.data));
        check("checksum_on_wr", 32'(checksum), 32'(mon_e.chk));
        if (mon_e.last) begin
          check("done_at_last", 32'(done), 32'd1);
          check("hold_at_last", 32'(cpu_hold), 32'd0);
          check("ready_at_last", 32'(in_ready), 32'd0);
        end else begin
          check("done_mid", 32'(done), 32'd0);
          check("hold_mid", 32'(cpu_hold), 32'd1);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    reset = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_cpu_hold", 32'(cpu_hold), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_checksum", 32'(checksum), 32'd0);
  endtask

  task automatic send(input byte_q_t b, input int gap,
                      input int start_at, output int cyc);
    int i;
    bit rdy;
    bit sp;
    i   = 0;
    sp  = 1'b0;
    cyc = 0;
    while (i < b.size() && cyc < 2000) begin
      @(negedge clk);
      if (i == start_at && !sp) begin
        start = 1'b1;
        sp    = 1'b1;
      end
      if (int'($urandom_range(0, 99)) < gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b[i];
      end
      rdy = in_ready;
      @(posedge clk);
      cyc++;
      if (in_valid && rdy) i++;
      #1;
      in_valid = 1'b0;
      start    = 1'b0;
    end
    if (i < b.size()) check("send_timeout", 32'(i), 32'(b.size()));
  endtask

  task automatic offer_idle(input string nm);
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      check(nm, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  byte_q_t basic;
  byte_q_t q;
  int      cyc;
  int      n;
  logic [WW-1:0] w;

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    basic = '{8'h00, 8'h03, 8'h12, 8'h34,
              8'hAB, 8'hCD, 8'h00, 8'h01};

    do_reset();
    offer_idle("idle_in_ready");

    do_start();
    model(basic);
    send(basic, 0, -1, cyc);
    check("basic_cycles", 32'(cyc), 32'd8);
    @(negedge clk);
    check("basic_wr_en", 32'(wr_en), 32'd1);
    check("basic_done", 32'(done), 32'd1);
    check("basic_hold", 32'(cpu_hold), 32'd0);
    check("basic_busy", 32'(busy), 32'd0);
    check("basic_checksum", 32'(checksum), 32'h0000BE02);
    @(negedge clk);
    check("basic_wr_pulse", 32'(wr_en), 32'd0);
    offer_idle("done_in_ready");
    check("done_held", 32'(done), 32'd1);

    do_start();
    q = '{8'h00, 8'h01, 8'hFF, 8'hFF};
    model(q);
    send(q, 0, -1, cyc);
    @(negedge clk);
    check("restart_checksum", 32'(checksum), 32'h0000FFFF);
    check("restart_done", 32'(done), 32'd1);

    do_start();
    q = '{8'h00, 8'h00};
    model(q);
    send(q, 0, -1, cyc);
    @(negedge clk);
    check("empty_done", 32'(done), 32'd1);
    check("empty_wr_en", 32'(wr_en), 32'd0);
    check("empty_checksum", 32'(checksum), 32'd0);

    do_start();
    model(basic);
    send(basic, 50, -1, cyc);
    @(negedge clk);
    check("gap_checksum", 32'(checksum), 32'h0000BE02);
    check("gap_done", 32'(done), 32'd1);

    do_start();
    model(basic);
    send(basic, 0, 4, cyc);
    check("busy_start_cycles", 32'(cyc), 32'd8);
    @(negedge clk);
    check("busy_start_checksum", 32'(checksum), 32'h0000BE02);
    check("busy_start_done", 32'(done), 32'd1);

    do_start();
    q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB};
    model(q);
    send(q, 0, -1, cyc);
    do_reset();
    do_start();
    model(basic);
    send(basic, 0, -1, cyc);
    @(negedge clk);
    check("post_rst_checksum", 32'(checksum), 32'h0000BE02);

    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(1, 6));
      q = {};
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      for (int k = 0; k < n; k++) begin
        w = WW'($urandom);
        q.push_back(w[15:8]);
        q.push_back(w[7:0]);
      end
      do_start();
      model(q);
      send(q, 30, (it % 2 == 0) ? 3 : -1, cyc);
      @(negedge clk);
      check("rand_done", 32'(done), 32'd1);
      check("rand_checksum", 32'(checksum), 32'(last_sum));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
